// File: rtl/prbs_gen_if.sv
// Word stream leaving the PRBS generator: valid/ready handshake with data and start-of-period flag.
interface prbs_gen_if #(
    parameter int WIDTH = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sop;

    modport master (output out_valid, output out_data, output out_sop, input out_ready);
    modport slave  (input out_valid, input out_data, input out_sop, output out_ready);
endinterface

// File: rtl/prbs_gen.sv
// Fibonacci LFSR pseudo-random word generator: WIDTH serial steps unrolled per cycle,
// with a period-position counter that flags words containing bit index 0 of the sequence.
module prbs_gen #(
    parameter int LEN   = 15,
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           stop,
    input  logic           seed_load,
    input  logic [LEN-1:0] seed_in,
    output logic           seed_zero,
    output logic           busy,
    prbs_gen_if.master     out
);

    // Tap t of the polynomial maps to mask bit t-1.
    function automatic logic [15:0] tap_mask(input int n);
        case (n)
            2:       tap_mask = 16'h0003;
            3:       tap_mask = 16'h0006;
            4:       tap_mask = 16'h000C;
            5:       tap_mask = 16'h0014;
            6:       tap_mask = 16'h0030;
            7:       tap_mask = 16'h0048;
            8:       tap_mask = 16'h00B8;
            9:       tap_mask = 16'h0110;
            10:      tap_mask = 16'h0240;
            11:      tap_mask = 16'h0500;
            12:      tap_mask = 16'h0CA0;
            13:      tap_mask = 16'h1B00;
            14:      tap_mask = 16'h3088;
            15:      tap_mask = 16'h6000;
            16:      tap_mask = 16'hD008;
            default: tap_mask = 16'h0000;
        endcase
    endfunction

    localparam logic [15:0]    TAP16   = tap_mask(LEN);
    localparam logic [LEN-1:0] TAPS    = TAP16[LEN-1:0];
    localparam int             PER     = (1 << LEN) - 1;
    localparam int             SOP_LIM = PER - WIDTH;
    localparam int             AW      = LEN + 5;

    function automatic logic [WIDTH+LEN-1:0] gen_word(input logic [LEN-1:0] s);
        logic [LEN-1:0]   st;
        logic [WIDTH-1:0] w;
        st = s;
        w  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w[WIDTH-1-i] = st[LEN-1];
            st = {st[LEN-2:0], ^(st & TAPS)};
        end
        return {w, st};
    endfunction

    // Modular add of WIDTH; WIDTH may exceed a short period, so subtract repeatedly.
    function automatic logic [LEN-1:0] per_adv(input logic [LEN-1:0] p);
        logic [AW-1:0] acc;
        acc = {5'b0, p} + AW'(WIDTH);
        for (int i = 0; i < 6; i++) begin
            if (acc >= AW'(PER))
                acc = acc - AW'(PER);
        end
        return acc[LEN-1:0];
    endfunction

    function automatic logic sop_of(input logic [LEN-1:0] p);
        logic signed [LEN:0] ps;
        ps = $signed({1'b0, p});
        return (p == '0) || (ps > SOP_LIM);
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [LEN-1:0]   lfsr_q, lfsr_d, lfsr_nxt;
    logic [LEN-1:0]   per_q, per_d;
    logic [WIDTH-1:0] word_nxt;
    logic [WIDTH-1:0] data_p0, data_d;
    logic             sop_p0, sop_d;
    logic             vld_p0, vld_d;
    logic             zero_q, zero_d;
    logic             gen;

    assign {word_nxt, lfsr_nxt} = gen_word(lfsr_q);

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        per_d   = per_q;
        data_d  = data_p0;
        sop_d   = sop_p0;
        vld_d   = vld_p0;
        zero_d  = 1'b0;
        gen     = 1'b0;
        if (seed_load) begin
            lfsr_d  = (seed_in == '0) ? '1 : seed_in;
            zero_d  = (seed_in == '0);
            per_d   = '0;
            vld_d   = 1'b0;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        gen     = 1'b1;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (vld_p0 && out.out_ready) begin
                        if (stop) begin
                            vld_d   = 1'b0;
                            state_d = IDLE;
                        end else begin
                            gen = 1'b1;
                        end
                    end else if (stop) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (vld_p0 && out.out_ready) begin
                        vld_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (gen) begin
                lfsr_d = lfsr_nxt;
                per_d  = per_adv(per_q);
                data_d = word_nxt;
                sop_d  = sop_of(per_q);
                vld_d  = 1'b1;
            end
        end
    end

    // Output word register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= '1;
            per_q   <= '0;
            data_p0 <= '0;
            sop_p0  <= 1'b0;
            vld_p0  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            per_q   <= per_d;
            data_p0 <= data_d;
            sop_p0  <= sop_d;
            vld_p0  <= vld_d;
            zero_q  <= zero_d;
        end
    end

    assign out.out_valid = vld_p0;
    assign out.out_data  = data_p0;
    assign out.out_sop   = sop_p0;
    assign seed_zero     = zero_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_prbs_gen.sv
// Directed bench for prbs_gen: four instances cover LEN=4 (WIDTH 8 and 1) and LEN=15/16 at WIDTH 16.
module tb_prbs_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  start = '0, stop = '0, seed_load = '0, rdy = '0;
    logic [3:0]  seed_a = '0, seed_b = '0;
    logic [14:0] seed_c = '0;
    logic [15:0] seed_d = '0;
    logic [3:0]  sz, busy;
    int          n_chk = 0, n_pass = 0;

    // One period of the LEN=4 sequence, earliest bit in the MSB.
    logic [14:0] pat = 15'b111100010011010;

    always #5 clk = ~clk;

    prbs_gen_if #(.WIDTH(8))  if_a ();
    prbs_gen_if #(.WIDTH(1))  if_b ();
    prbs_gen_if #(.WIDTH(16)) if_c ();
    prbs_gen_if #(.WIDTH(16)) if_d ();

    assign if_a.out_ready = rdy[0];
    assign if_b.out_ready = rdy[1];
    assign if_c.out_ready = rdy[2];
    assign if_d.out_ready = rdy[3];

    prbs_gen #(.LEN(4), .WIDTH(8)) dut_a (
        .clk(clk), .rst(rst), .start(start[0]), .stop(stop[0]), .seed_load(seed_load[0]),
        .seed_in(seed_a), .seed_zero(sz[0]), .busy(busy[0]), .out(if_a));
    prbs_gen #(.LEN(4), .WIDTH(1)) dut_b (
        .clk(clk), .rst(rst), .start(start[1]), .stop(stop[1]), .seed_load(seed_load[1]),
        .seed_in(seed_b), .seed_zero(sz[1]), .busy(busy[1]), .out(if_b));
    prbs_gen #(.LEN(15), .WIDTH(16)) dut_c (
        .clk(clk), .rst(rst), .start(start[2]), .stop(stop[2]), .seed_load(seed_load[2]),
        .seed_in(seed_c), .seed_zero(sz[2]), .busy(busy[2]), .out(if_c));
    prbs_gen #(.LEN(16), .WIDTH(16)) dut_d (
        .clk(clk), .rst(rst), .start(start[3]), .stop(stop[3]), .seed_load(seed_load[3]),
        .seed_in(seed_d), .seed_zero(sz[3]), .busy(busy[3]), .out(if_d));

    function automatic logic [7:0] exp_w8(input int k);
        logic [7:0] w;
        for (int j = 0; j < 8; j++) w[7-j] = pat[14 - ((8*k + j) % 15)];
        return w;
    endfunction

    function automatic logic exp_sop8(input int k);
        int p;
        p = (8*k) % 15;
        return (p == 0) || (p > 7);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        start = '0; stop = '0; seed_load = '0; rdy = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        #12;
        n_chk++; if (if_a.out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", if_a.out_valid); else n_pass++;
        n_chk++; if (if_a.out_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", if_a.out_data); else n_pass++;
        n_chk++; if ({if_a.out_sop, sz[0], busy[0]} !== 3'b000)
            $display("FAIL reset_flags got=%b exp=000", {if_a.out_sop, sz[0], busy[0]}); else n_pass++;
        start[0] = 1'b1; rdy[0] = 1'b1;
        tick();
        n_chk++; if (if_a.out_valid !== 1'b0) $display("FAIL reset_hold_start got=%b exp=0", if_a.out_valid); else n_pass++;
        start[0] = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_first_word;
        int errs;
        logic [7:0] w15;
        errs = 0; w15 = '0;
        do_reset();
        rdy[0] = 1'b1; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        n_chk++; if (if_a.out_data !== 8'hF1) $display("FAIL first_word got=%h exp=f1", if_a.out_data); else n_pass++;
        n_chk++; if ({if_a.out_valid, if_a.out_sop, busy[0]} !== 3'b111)
            $display("FAIL first_flags got=%b exp=111", {if_a.out_valid, if_a.out_sop, busy[0]}); else n_pass++;
        tick();
        n_chk++; if ({if_a.out_data, if_a.out_sop} !== {8'h35, 1'b1})
            $display("FAIL second_word got=%h/%b exp=35/1", if_a.out_data, if_a.out_sop); else n_pass++;
        for (int k = 2; k <= 16; k++) begin
            tick();
            if (k == 15) w15 = if_a.out_data;
            if (if_a.out_data !== exp_w8(k) || if_a.out_sop !== exp_sop8(k) || if_a.out_valid !== 1'b1) begin
                if (errs == 0) $display("FAIL w8_stream word=%0d got=%h/%b exp=%h/%b", k, if_a.out_data, if_a.out_sop, exp_w8(k), exp_sop8(k));
                errs++;
            end
        end
        n_chk++; if (errs != 0) $display("FAIL w8_stream_errors got=%0d exp=0", errs); else n_pass++;
        n_chk++; if (w15 !== 8'hF1) $display("FAIL w8_period_repeat got=%h exp=f1", w15); else n_pass++;
    endtask

    task automatic test_serial;
        int errs, sops;
        errs = 0; sops = 0;
        do_reset();
        rdy[1] = 1'b1; start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        for (int k = 0; k < 45; k++) begin
            if (if_b.out_sop === 1'b1) sops++;
            if (if_b.out_data[0] !== pat[14 - (k % 15)] || if_b.out_sop !== (k % 15 == 0)) begin
                if (errs == 0) $display("FAIL serial_bit idx=%0d got=%b/%b exp=%b/%b", k, if_b.out_data[0], if_b.out_sop, pat[14 - (k % 15)], (k % 15 == 0));
                errs++;
            end
            tick();
        end
        n_chk++; if (errs != 0) $display("FAIL serial_errors got=%0d exp=0", errs); else n_pass++;
        n_chk++; if (sops != 3) $display("FAIL serial_sop_count got=%0d exp=3", sops); else n_pass++;
    endtask

    task automatic test_backpressure;
        int errs;
        errs = 0;
        do_reset();
        rdy[0] = 1'b1; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick();
        tick();
        rdy[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (if_a.out_data !== 8'hE2 || if_a.out_sop !== 1'b0 || if_a.out_valid !== 1'b1) begin
                if (errs == 0) $display("FAIL hold_word cyc=%0d got=%h/%b exp=e2/0", c, if_a.out_data, if_a.out_sop);
                errs++;
            end
        end
        n_chk++; if (errs != 0) $display("FAIL hold_errors got=%0d exp=0", errs); else n_pass++;
        rdy[0] = 1'b1;
        tick();
        n_chk++; if ({if_a.out_data, if_a.out_sop} !== {8'h6B, 1'b1})
            $display("FAIL resume_word got=%h/%b exp=6b/1", if_a.out_data, if_a.out_sop); else n_pass++;
        tick();
        n_chk++; if ({if_a.out_data, if_a.out_sop} !== {exp_w8(4), exp_sop8(4)})
            $display("FAIL resume_next got=%h/%b exp=%h/%b", if_a.out_data, if_a.out_sop, exp_w8(4), exp_sop8(4)); else n_pass++;
    endtask

    task automatic test_seed;
        do_reset();
        rdy[0] = 1'b1; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick();
        seed_load[0] = 1'b1; seed_a = 4'h0;
        tick();
        seed_load[0] = 1'b0;
        n_chk++; if ({sz[0], if_a.out_valid, busy[0]} !== 3'b100)
            $display("FAIL seed_zero_load got=%b exp=100", {sz[0], if_a.out_valid, busy[0]}); else n_pass++;
        tick();
        n_chk++; if ({sz[0], if_a.out_valid} !== 2'b00)
            $display("FAIL seed_zero_pulse got=%b exp=00", {sz[0], if_a.out_valid}); else n_pass++;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        n_chk++; if ({if_a.out_data, if_a.out_sop} !== {8'hF1, 1'b1})
            $display("FAIL seed_zero_restart got=%h/%b exp=f1/1", if_a.out_data, if_a.out_sop); else n_pass++;
        seed_load[0] = 1'b1; seed_a = 4'h1;
        tick();
        seed_load[0] = 1'b0;
        n_chk++; if (sz[0] !== 1'b0) $display("FAIL seed_nonzero_flag got=%b exp=0", sz[0]); else n_pass++;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        n_chk++; if ({if_a.out_data, if_a.out_sop} !== {8'h13, 1'b1})
            $display("FAIL seed_custom_word got=%h/%b exp=13/1", if_a.out_data, if_a.out_sop); else n_pass++;
    endtask

    task automatic test_drain;
        int errs;
        errs = 0;
        do_reset();
        rdy[0] = 1'b1; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        rdy[0] = 1'b0; stop[0] = 1'b1;
        tick();
        stop[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if ({if_a.out_valid, busy[0], if_a.out_data} !== {2'b11, 8'hF1}) begin
                if (errs == 0) $display("FAIL drain_hold cyc=%0d got=%b/%h exp=11/f1", c, {if_a.out_valid, busy[0]}, if_a.out_data);
                errs++;
            end
            if (c < 2) tick();
        end
        n_chk++; if (errs != 0) $display("FAIL drain_hold_errors got=%0d exp=0", errs); else n_pass++;
        rdy[0] = 1'b1;
        tick();
        n_chk++; if ({if_a.out_valid, busy[0]} !== 2'b00)
            $display("FAIL drain_accept got=%b exp=00", {if_a.out_valid, busy[0]}); else n_pass++;
        stop[0] = 1'b1;
        tick();
        stop[0] = 1'b0;
        n_chk++; if ({if_a.out_valid, busy[0]} !== 2'b00)
            $display("FAIL stop_in_idle got=%b exp=00", {if_a.out_valid, busy[0]}); else n_pass++;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        n_chk++; if ({if_a.out_valid, if_a.out_data, if_a.out_sop} !== {1'b1, 8'h35, 1'b1})
            $display("FAIL after_drain_word got=%b/%h/%b exp=1/35/1", if_a.out_valid, if_a.out_data, if_a.out_sop); else n_pass++;
        stop[0] = 1'b1;
        tick();
        stop[0] = 1'b0;
        n_chk++; if ({if_a.out_valid, busy[0]} !== 2'b00)
            $display("FAIL stop_accepted got=%b exp=00", {if_a.out_valid, busy[0]}); else n_pass++;
        start[0] = 1'b1;
        tick();
        rdy[0] = 1'b0;
        tick();
        start[0] = 1'b0;
        n_chk++; if ({if_a.out_valid, if_a.out_data} !== {1'b1, 8'hE2})
            $display("FAIL start_in_run got=%b/%h exp=1/e2", if_a.out_valid, if_a.out_data); else n_pass++;
        seed_load[0] = 1'b1; start[0] = 1'b1; seed_a = 4'hF;
        tick();
        seed_load[0] = 1'b0; start[0] = 1'b0;
        n_chk++; if ({if_a.out_valid, busy[0]} !== 2'b00)
            $display("FAIL seed_over_start got=%b exp=00", {if_a.out_valid, busy[0]}); else n_pass++;
    endtask

    task automatic test_reset_mid;
        do_reset();
        rdy[0] = 1'b1; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        n_chk++; if ({if_a.out_valid, if_a.out_data, if_a.out_sop, busy[0]} !== 11'b0)
            $display("FAIL async_reset got=%b/%h/%b/%b exp=0/00/0/0", if_a.out_valid, if_a.out_data, if_a.out_sop, busy[0]); else n_pass++;
        tick();
        rst = 1'b0;
        tick();
        tick();
        n_chk++; if (if_a.out_valid !== 1'b0) $display("FAIL reset_no_output got=%b exp=0", if_a.out_valid); else n_pass++;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        n_chk++; if (if_a.out_data !== 8'hF1) $display("FAIL reset_restart got=%h exp=f1", if_a.out_data); else n_pass++;
    endtask

    task automatic test_long_period;
        logic [14:0] m15;
        logic [15:0] m16, e15, e16, f15, f16;
        int errc, errd, sopc, sopd, runc, rund, maxc, maxd;
        logic sop_end_c, sop_end_d, rep_c, rep_d;
        m15 = '1; m16 = '1; f15 = '0; f16 = '0;
        errc = 0; errd = 0; sopc = 0; sopd = 0; runc = 0; rund = 0; maxc = 0; maxd = 0;
        sop_end_c = 1'b0; sop_end_d = 1'b0; rep_c = 1'b0; rep_d = 1'b0;
        do_reset();
        rdy[2] = 1'b1; rdy[3] = 1'b1; start[2] = 1'b1; start[3] = 1'b1;
        tick();
        start[2] = 1'b0; start[3] = 1'b0;
        for (int k = 0; k <= 65535; k++) begin
            for (int j = 0; j < 16; j++) begin
                e16[15-j] = m16[15];
                m16 = {m16[14:0], m16[15] ^ m16[14] ^ m16[12] ^ m16[3]};
                rund = (if_d.out_data[15-j] === 1'b0) ? rund + 1 : 0;
                if (rund > maxd) maxd = rund;
            end
            if (k == 0) f16 = if_d.out_data;
            if (k < 65535 && if_d.out_sop === 1'b1) sopd++;
            if (k == 65535) begin sop_end_d = if_d.out_sop; rep_d = (if_d.out_data === f16); end
            if (if_d.out_data !== e16) begin
                if (errd == 0) $display("FAIL len16_word k=%0d got=%h exp=%h", k, if_d.out_data, e16);
                errd++;
            end
            if (k <= 32767) begin
                for (int j = 0; j < 16; j++) begin
                    e15[15-j] = m15[14];
                    m15 = {m15[13:0], m15[14] ^ m15[13]};
                    runc = (if_c.out_data[15-j] === 1'b0) ? runc + 1 : 0;
                    if (runc > maxc) maxc = runc;
                end
                if (k == 0) f15 = if_c.out_data;
                if (k < 32767 && if_c.out_sop === 1'b1) sopc++;
                if (k == 32767) begin sop_end_c = if_c.out_sop; rep_c = (if_c.out_data === f15); end
                if (if_c.out_data !== e15) begin
                    if (errc == 0) $display("FAIL len15_word k=%0d got=%h exp=%h", k, if_c.out_data, e15);
                    errc++;
                end
            end
            tick();
        end
        n_chk++; if (errc != 0) $display("FAIL len15_errors got=%0d exp=0", errc); else n_pass++;
        n_chk++; if (errd != 0) $display("FAIL len16_errors got=%0d exp=0", errd); else n_pass++;
        n_chk++; if (sopc != 16) $display("FAIL len15_sop_count got=%0d exp=16", sopc); else n_pass++;
        n_chk++; if (sopd != 16) $display("FAIL len16_sop_count got=%0d exp=16", sopd); else n_pass++;
        n_chk++; if ({sop_end_c, rep_c, sop_end_d, rep_d} !== 4'b1111)
            $display("FAIL period_repeat got=%b exp=1111", {sop_end_c, rep_c, sop_end_d, rep_d}); else n_pass++;
        n_chk++; if (maxc >= 15 || maxd >= 16)
            $display("FAIL zero_run got=%0d/%0d exp=<15/<16", maxc, maxd); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_serial();
        test_backpressure();
        test_seed();
        test_drain();
        test_reset_mid();
        test_long_period();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/prbs_gen.md
PRBS_GEN -- requirements
Module: prbs_gen

Interface
REQ-001 Parameter LEN, default 15: LFSR length in bits, legal range 2..16.
REQ-002 Parameter WIDTH, default 8: serial bits delivered per output word, legal range 1..16.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin word generation.
REQ-006 stop  input  1  single-cycle request to end generation after the pending word.
REQ-007 seed_load  input  1  load seed_in into the LFSR.
REQ-008 seed_in  input  LEN  seed value.
REQ-009 out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 out_valid  output  1  out_data holds a valid word.
REQ-011 out_data  output  WIDTH  word; bit WIDTH-1 is the earliest serial bit.
REQ-012 out_sop  output  1  current word contains period bit index 0.
REQ-013 seed_zero  output  1  one-cycle pulse: an all-zero seed was replaced.
REQ-014 busy  output  1  high whenever the state machine is not IDLE.

Function
REQ-015 LFSR state S[LEN-1:0]: each serial step emits S[LEN-1], shifts S left by one, and writes the feedback bit into S[0].
REQ-016 Feedback SHALL be the XOR of S[t-1] over the fixed tap set for LEN. Tap sets: 2:{2,1} 3:{3,2} 4:{4,3} 5:{5,3} 6:{6,5} 7:{7,4} 8:{8,6,5,4} 9:{9,5} 10:{10,7} 11:{11,9} 12:{12,11,8,6} 13:{13,12,10,9} 14:{14,13,8,4} 15:{15,14} 16:{16,15,13,4}.
REQ-017 One word SHALL equal WIDTH consecutive serial steps computed in a single cycle (unrolled), with the LFSR advanced by WIDTH steps per word.
REQ-018 The state machine SHALL have states IDLE, RUN and DRAIN.
REQ-019 IDLE + start: compute a word, set out_valid, enter RUN; out_valid rises on the edge that samples start.
REQ-020 RUN, out_valid && out_ready: the next word SHALL replace out_data at the same edge and out_valid SHALL stay high, giving one word per cycle under continuous ready.
REQ-021 While out_valid && !out_ready, out_data, out_sop and the LFSR SHALL hold unchanged.
REQ-022 RUN + stop: if the word is accepted in the same cycle, clear out_valid and go to IDLE; otherwise go to DRAIN.
REQ-023 DRAIN: on acceptance, clear out_valid, go to IDLE, and advance no further word.
REQ-024 Period counter P counts serial bits modulo 2^LEN-1 and is advanced by WIDTH (modulo) with each word generated.
REQ-025 out_sop SHALL be 1 when P at word start equals 0 or is greater than (2^LEN-1)-WIDTH.
REQ-026 seed_load in any state SHALL load S, clear P to 0, clear out_valid and go to IDLE.
REQ-027 seed_load with seed_in all zero SHALL load all-ones instead and pulse seed_zero for one cycle.
REQ-028 seed_load has priority over start and stop in the same cycle; start is ignored outside IDLE; stop is ignored in IDLE.
REQ-029 out_ready is ignored while out_valid is 0.

Reset
REQ-030 rst SHALL asynchronously force: S all-ones, P=0, state IDLE, out_valid=0, out_data=0, out_sop=0, seed_zero=0, busy=0.
REQ-031 Reset asserted mid-operation discards any pending word; no output is produced until a new start.

Verification
REQ-032 LEN=4, WIDTH=8, reset, start, out_ready=1 -> first word 8'hF1 with out_sop=1; 15-bit period repeats the serial stream exactly.
REQ-033 LEN=4, WIDTH=1, continuous ready -> serial stream 1,1,1,1,0,0,0,1,..., period 15, out_sop=1 every 15th word.
REQ-034 Hold out_ready=0 for 5 cycles mid-stream -> out_data and out_sop stable; stream resumes with no lost or repeated bits.
REQ-035 seed_load with seed_in=0 -> seed_zero pulse, S=all-ones, IDLE; next start reproduces the reset sequence.
REQ-036 stop with out_ready=0, then ready after 3 cycles -> DRAIN held for 3 cycles, one word accepted, IDLE; seed_load+start in the same cycle -> IDLE, out_valid=0.
REQ-037 LEN=15 and LEN=16, WIDTH=16 -> counted period 2^LEN-1 and no all-zero state reached.
